fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Parametrised instruction-fetch stage for the pipelined core. Successor to the single-cycle free-running PC/PC+4 logic.
- Owns the PC register and next-PC selection (sequential, branch, jal, jalr) and drives the external instruction memory address.
- Holds the IF/ID pipeline register with stall, flush and a valid bit.
- Feeds decode; accepts redirects resolved in EX.

Parameters:
- PC_W, 9, PC and instruction-memory address width (bytes).
- INS_W, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, bubble encoding (addi x0,x0,0) placed in IF/ID on reset or flush.
- CNT_W, 16, width of the saturating redirect counter.

Ports:
- clk  input  1  global clock, rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- stall  input  1  hazard-unit stall; freezes PC and IF/ID.
- ex_branch  input  1  EX-stage instruction is a conditional branch.
- ex_zero  input  1  EX-stage ALU zero flag (branch condition true).
- ex_jump  input  1  EX-stage instruction is jal or jalr.
- ex_jalr  input  1  qualifies ex_jump: 1 = jalr, 0 = jal.
- ex_pc  input  PC_W  PC of the EX-stage instruction.
- ex_imm  input  32  sign-extended immediate of the EX-stage instruction.
- ex_alu_result  input  32  rs1+imm for jalr.
- imem_addr  output  PC_W  equals current PC (combinational from the register).
- imem_rdata  input  INS_W  combinational instruction read.
- if_id_pc  output  PC_W  PC of the instruction held in IF/ID.
- if_id_pc_plus4  output  PC_W  if_id_pc+4, used for the jal/jalr link value.
- if_id_instr  output  INS_W  instruction held in IF/ID.
- if_id_valid  output  1  IF/ID holds a real instruction.
- flush_ex  output  1  combinational; high in any redirect cycle so ID/EX is bubbled downstream.
- redirect_cnt  output  CNT_W  count of taken redirects.

Behaviour:
- Redirect conditions (combinational):
  - take_br = ex_branch & ex_zero.
  - take_jal = ex_jump & ~ex_jalr.
  - take_jalr = ex_jump & ex_jalr.
  - redirect = take_br | take_jal | take_jalr.
  - flush_ex = redirect.
- Target:
  - jalr: ex_alu_result[PC_W-1:0] with bit0 cleared.
  - br/jal: (ex_pc + ex_imm[PC_W-1:0]) mod 2^PC_W.
  - In all cases target bits[1:0] are forced to 0.
- Next-PC priority, per rising edge:
  - reset: PC = RESET_PC.
  - else redirect: PC = target. Redirect overrides stall.
  - else stall: PC holds.
  - else: PC = PC+4, wrapping modulo 2^PC_W (for example 0x1FC -> 0x000 at PC_W=9).
- IF/ID register, same priority:
  - reset or redirect: instr = NOP_INSTR, valid = 0, pc = 0, pc_plus4 = 0.
  - else stall: all fields hold.
  - else: instr = imem_rdata, pc = PC, pc_plus4 = PC+4 (wrapped), valid = 1.
- Latency:
  - An instruction appears at the IF/ID outputs one cycle after its PC is presented on imem_addr.
  - A redirect costs 2 bubbles: the IF/ID flush plus the flush_ex-driven ID/EX bubble.
- redirect_cnt:
  - Reset to 0.
  - +1 on each cycle with redirect=1 and reset=0; saturates at all-ones.
  - Unaffected by stall.
- Reset values: PC=RESET_PC, imem_addr=RESET_PC, if_id_instr=NOP_INSTR, if_id_valid=0, if_id_pc=0, if_id_pc_plus4=0, redirect_cnt=0.
- Reset asserted mid-redirect or mid-stall wins over everything.
- Simultaneous ex_branch and ex_jump (illegal from decode): ex_jump takes precedence in target selection.

Test Plan:
- Reset then 4 free-running cycles with imem_rdata = 0xAAAA0000+PC -> imem_addr 0,4,8,C. Cycle 1 shows IF/ID pc=0, instr=0xAAAA0000, valid=1. Before the first edge after reset: valid=0, instr=0x13.
- Stall held 3 cycles at PC=8 -> imem_addr stays 8, IF/ID frozen (pc=4). Release -> PC 0xC next edge.
- Branch taken (ex_branch=1, ex_zero=1, ex_pc=0x10, ex_imm=-8) -> next PC=0x08, IF/ID = NOP with valid=0, flush_ex=1, redirect_cnt=1. Repeat with ex_zero=0 -> no redirect.
- jalr with ex_alu_result=0x123 -> PC=0x120 (low bits cleared). jal with ex_pc=0x1F0, ex_imm=0x20 -> PC=0x010 (wrap).
- Redirect and stall in the same cycle -> PC loads the target and IF/ID is flushed. Reset asserted during a redirect -> PC=RESET_PC and redirect_cnt=0.
- Wrap and saturation: free-run from PC=0x1FC -> 0x000. With CNT_W=2, 5 redirects -> redirect_cnt=3.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// Redirects resolved in EX override stall; reset overrides everything.
module fetch_stage #(
  parameter int unsigned      PC_W      = 9,
  parameter int unsigned      INS_W     = 32,
  parameter logic [PC_W-1:0]  RESET_PC  = '0,
  parameter logic [INS_W-1:0] NOP_INSTR = 32'h00000013,
  parameter int unsigned      CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             ex_branch,
  input  logic             ex_zero,
  input  logic             ex_jump,
  input  logic             ex_jalr,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic [31:0]      ex_imm,
  input  logic [31:0]      ex_alu_result,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [INS_W-1:0] imem_rdata,
  output logic [PC_W-1:0]  if_id_pc,
  output logic [PC_W-1:0]  if_id_pc_plus4,
  output logic [INS_W-1:0] if_id_instr,
  output logic             if_id_valid,
  output logic             flush_ex,
  output logic [CNT_W-1:0] redirect_cnt
);

  logic             w_take_br;
  logic             w_take_jal;
  logic             w_take_jalr;
  logic             w_redirect;
  logic [PC_W-1:0]  w_pc_plus4;
  logic [PC_W-1:0]  w_raw_target;
  logic [PC_W-1:0]  w_target;
  logic             w_unused;

  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  r_if_id_pc;
  logic [PC_W-1:0]  r_if_id_pc_plus4;
  logic [INS_W-1:0] r_if_id_instr;
  logic             r_if_id_valid;
  logic [CNT_W-1:0] r_redirect_cnt;

  always_comb begin
    w_take_br   = ex_branch & ex_zero;
    w_take_jal  = ex_jump & ~ex_jalr;
    w_take_jalr = ex_jump & ex_jalr;
    w_redirect  = w_take_br | w_take_jal | w_take_jalr;
    w_pc_plus4  = r_pc + PC_W'(4);
    // Branch and jal share the pc+imm adder, so a jump wins target selection
    // only through the jalr mux. Forcing bits[1:0] to zero subsumes jalr's bit0 clear.
    w_raw_target = w_take_jalr ? ex_alu_result[PC_W-1:0] : (ex_pc + ex_imm[PC_W-1:0]);
    w_target     = {w_raw_target[PC_W-1:2], 2'b00};
  end

  assign w_unused = ^{ex_imm[31:PC_W], ex_alu_result[31:PC_W], w_raw_target[1:0], w_take_jal};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (w_redirect) begin
      r_pc <= w_target;
    end else if (!stall) begin
      r_pc <= w_pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_redirect) begin
      r_if_id_instr    <= NOP_INSTR;
      r_if_id_valid    <= 1'b0;
      r_if_id_pc       <= '0;
      r_if_id_pc_plus4 <= '0;
    end else if (!stall) begin
      r_if_id_instr    <= imem_rdata;
      r_if_id_valid    <= 1'b1;
      r_if_id_pc       <= r_pc;
      r_if_id_pc_plus4 <= w_pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_redirect_cnt <= '0;
    end else if (w_redirect && (r_redirect_cnt != '1)) begin
      r_redirect_cnt <= r_redirect_cnt + CNT_W'(1);
    end
  end

  assign imem_addr      = r_pc;
  assign if_id_pc       = r_if_id_pc;
  assign if_id_pc_plus4 = r_if_id_pc_plus4;
  assign if_id_instr    = r_if_id_instr;
  assign if_id_valid    = r_if_id_valid;
  assign flush_ex       = w_redirect;
  assign redirect_cnt   = r_redirect_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a per-cycle reference model checked at every negedge,
// plus literal expectations from directed fetch/stall/redirect scenarios.
module tb_fetch_stage;

  localparam int unsigned CW    = 2;
  localparam int unsigned CMAX  = (1 << CW) - 1;
  localparam int unsigned PMASK = 32'h1FF;

  logic        clk = 1'b0;
  logic        reset, stall, ex_branch, ex_zero, ex_jump, ex_jalr;
  logic [8:0]  ex_pc;
  logic [31:0] ex_imm, ex_alu_result;
  logic [8:0]  imem_addr, if_id_pc, if_id_pc_plus4;
  logic [31:0] imem_rdata, if_id_instr;
  logic        if_id_valid, flush_ex;
  logic [CW-1:0] redirect_cnt;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  fetch_stage #(.PC_W(9), .INS_W(32), .RESET_PC(9'h000), .NOP_INSTR(32'h00000013), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .ex_branch(ex_branch), .ex_zero(ex_zero), .ex_jump(ex_jump), .ex_jalr(ex_jalr),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_alu_result(ex_alu_result),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4), .if_id_instr(if_id_instr),
    .if_id_valid(if_id_valid), .flush_ex(flush_ex), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  // Instruction memory: each word encodes its own address.
  assign imem_rdata = 32'hAAAA0000 + {23'b0, imem_addr};

  task automatic cmp(input string nm, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_redir();
    return (ex_branch && ex_zero) || ex_jump;
  endfunction

  function automatic int unsigned m_target();
    int unsigned t;
    t = (ex_jump && ex_jalr) ? ex_alu_result : ({23'b0, ex_pc} + ex_imm);
    return t & 32'h1FC;
  endfunction

  int unsigned m_pc, m_ipc, m_ip4, m_instr, m_cnt;
  bit          m_valid;
  bit          m_known = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_pc <= 0; m_ipc <= 0; m_ip4 <= 0; m_instr <= 32'h13; m_valid <= 1'b0;
      m_cnt <= 0; m_known <= 1'b1;
    end else if (m_redir()) begin
      m_pc <= m_target(); m_ipc <= 0; m_ip4 <= 0; m_instr <= 32'h13; m_valid <= 1'b0;
      m_cnt <= (m_cnt < CMAX) ? m_cnt + 1 : m_cnt;
    end else if (!stall) begin
      m_ipc   <= m_pc;
      m_ip4   <= (m_pc + 4) & PMASK;
      m_instr <= 32'hAAAA0000 + m_pc;
      m_valid <= 1'b1;
      m_pc    <= (m_pc + 4) & PMASK;
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      cmp("m_imem_addr", imem_addr, m_pc);
      cmp("m_if_id_pc", if_id_pc, m_ipc);
      cmp("m_if_id_pc_plus4", if_id_pc_plus4, m_ip4);
      cmp("m_if_id_instr", if_id_instr, m_instr);
      cmp("m_if_id_valid", if_id_valid, m_valid);
      cmp("m_flush_ex", flush_ex, m_redir());
      cmp("m_redirect_cnt", redirect_cnt, m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; ex_branch = 1'b0; ex_zero = 1'b0; ex_jump = 1'b0; ex_jalr = 1'b0;
    ex_pc = '0; ex_imm = '0; ex_alu_result = '0;
    tick();
    cmp("rst_addr", imem_addr, 0);
    cmp("rst_valid", if_id_valid, 0);
    cmp("rst_instr", if_id_instr, 32'h13);
    cmp("rst_pc", if_id_pc, 0);
    cmp("rst_pc4", if_id_pc_plus4, 0);
    cmp("rst_cnt", redirect_cnt, 0);

    reset = 1'b0;
    tick();
    cmp("run1_addr", imem_addr, 9'h004);
    cmp("run1_pc", if_id_pc, 9'h000);
    cmp("run1_instr", if_id_instr, 32'hAAAA0000);
    cmp("run1_valid", if_id_valid, 1);
    tick();
    cmp("run2_addr", imem_addr, 9'h008);
    cmp("run2_pc", if_id_pc, 9'h004);

    stall = 1'b1;
    repeat (3) tick();
    cmp("stall_addr", imem_addr, 9'h008);
    cmp("stall_pc", if_id_pc, 9'h004);
    cmp("stall_instr", if_id_instr, 32'hAAAA0004);
    stall = 1'b0;
    tick();
    cmp("unstall_addr", imem_addr, 9'h00C);
    cmp("unstall_pc", if_id_pc, 9'h008);

    ex_branch = 1'b1; ex_zero = 1'b1; ex_pc = 9'h010; ex_imm = 32'hFFFF_FFF8;
    #1 cmp("br_flush", flush_ex, 1);
    tick();
    cmp("br_addr", imem_addr, 9'h008);
    cmp("br_valid", if_id_valid, 0);
    cmp("br_instr", if_id_instr, 32'h13);
    cmp("br_cnt", redirect_cnt, 1);

    ex_zero = 1'b0;
    #1 cmp("nbr_flush", flush_ex, 0);
    tick();
    cmp("nbr_addr", imem_addr, 9'h00C);
    cmp("nbr_cnt", redirect_cnt, 1);

    ex_branch = 1'b0; ex_jump = 1'b1; ex_jalr = 1'b1; ex_alu_result = 32'h0000_0123;
    tick();
    cmp("jalr_addr", imem_addr, 9'h120);
    cmp("jalr_cnt", redirect_cnt, 2);

    ex_jalr = 1'b0; ex_pc = 9'h1F0; ex_imm = 32'h20;
    tick();
    cmp("jal_wrap_addr", imem_addr, 9'h010);
    cmp("jal_cnt", redirect_cnt, 3);

    stall = 1'b1; ex_pc = 9'h100; ex_imm = 32'h4;
    tick();
    cmp("rs_addr", imem_addr, 9'h104);
    cmp("rs_valid", if_id_valid, 0);
    cmp("sat4_cnt", redirect_cnt, 3);

    ex_jalr = 1'b1; ex_alu_result = 32'h0000_01FF;
    tick();
    cmp("jalr_lowbits_addr", imem_addr, 9'h1FC);
    cmp("sat5_cnt", redirect_cnt, 3);

    ex_jump = 1'b0; ex_jalr = 1'b0; stall = 1'b0;
    tick();
    cmp("wrap_addr", imem_addr, 9'h000);
    cmp("wrap_pc", if_id_pc, 9'h1FC);
    cmp("wrap_pc4", if_id_pc_plus4, 9'h000);
    cmp("wrap_instr", if_id_instr, 32'hAAAA01FC);

    ex_branch = 1'b1; ex_zero = 1'b1; ex_jump = 1'b1; ex_jalr = 1'b1;
    ex_pc = 9'h040; ex_imm = 32'h8; ex_alu_result = 32'h80;
    tick();
    cmp("both_addr", imem_addr, 9'h080);

    reset = 1'b1; stall = 1'b1;
    tick();
    cmp("rstredir_addr", imem_addr, 9'h000);
    cmp("rstredir_cnt", redirect_cnt, 0);
    cmp("rstredir_valid", if_id_valid, 0);

    reset = 1'b0; stall = 1'b0; ex_branch = 1'b0; ex_zero = 1'b0; ex_jump = 1'b0; ex_jalr = 1'b0;
    repeat (3) tick();
    cmp("end_addr", imem_addr, 9'h00C);
    cmp("end_pc", if_id_pc, 9'h008);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
